// File: rtl/hexscan.sv
// hexscan: four-digit multiplexed hex 7-segment driver with frame-synchronous double-buffered load
module hexscan #(
  parameter int TICK_DIV = 50000,
  parameter int GAP_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  blank,
  output logic        ready,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame
);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [111:0] LUT = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                  7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  typedef enum logic [1:0] {OFF, SHOW, GAP} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0] dig_q, dig_d;
  logic [15:0] active_q, shadow_q;
  logic pending_q;
  logic [3:0] an_q;
  logic [6:0] seg_q;
  logic show_end, gap_end, commit, accept;
  logic [3:0] nib;
  always_comb begin
    show_end = tick_q == TW'(TICK_DIV - 1);
    gap_end = tick_q == TW'(GAP_CYC - 1);
    state_d = state_q;
    tick_d = tick_q + 1'b1;
    dig_d = dig_q;
    if ((state_q != SHOW && state_q != GAP) || !en) begin
      state_d = (state_q == OFF && en) ? SHOW : OFF;
      tick_d = '0;
      dig_d = '0;
    end else if (state_q == SHOW && show_end) begin
      state_d = GAP;
      tick_d = '0;
    end else if (state_q == GAP && gap_end) begin
      state_d = SHOW;
      tick_d = '0;
      dig_d = dig_q + 1'b1;
    end
    frame = !reset && en && (state_q == OFF || (state_q == GAP && gap_end && dig_q == 2'd3));
    // a pending value commits only between frames, or at once while scanning is off
    commit = pending_q && (state_q == OFF || frame);
    accept = load && !pending_q;
    nib = active_q[4*dig_q +: 4];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OFF;
      tick_q <= '0;
      dig_q <= '0;
      active_q <= '0;
      shadow_q <= '0;
      pending_q <= 1'b0;
      an_q <= 4'hF;
      seg_q <= 7'h7F;
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      dig_q <= dig_d;
      if (accept) shadow_q <= data;
      if (accept) pending_q <= 1'b1;
      if (commit) active_q <= shadow_q;
      if (commit) pending_q <= 1'b0;
      an_q <= (state_q == SHOW) ? ~(4'b0001 << dig_q) : 4'hF;
      seg_q <= (state_q == SHOW && !blank[dig_q]) ? LUT[7*nib +: 7] : 7'h7F;
    end
  end
  assign ready = !pending_q;
  assign an = an_q;
  assign seg = seg_q;
endmodule

// File: tb/tb_hexscan.sv
// tb_hexscan: table vectors, directed handshake/reset sequences and random stimulus against a frame-position model
module tb_hexscan;
  localparam int TD = 4, GC = 1, P = TD + GC, FR = 4 * P;
  logic clk = 0, reset = 1, en = 0, load = 0;
  logic [15:0] data = '0;
  logic [3:0] blank = '0;
  logic ready, frame;
  logic [3:0] an;
  logic [6:0] seg;
  hexscan #(.TICK_DIV(TD), .GAP_CYC(GC)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .data(data), .blank(blank),
    .ready(ready), .an(an), .seg(seg), .frame(frame)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [6:0] dec [16];
  bit m_run, m_pend;
  int m_pos;
  logic [15:0] m_act, m_sh;
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic [6:0] obs [4];
  typedef struct packed {logic [15:0] d; logic ld; logic [3:0] b; logic [27:0] e;} vec_t;
  vec_t vt [6];
  task automatic chk(string n, logic [15:0] a, logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic clear_obs();
    for (int i = 0; i < 4; i++) obs[i] = 7'h55;
  endtask
  task automatic step(bit r, bit e, bit l, logic [15:0] d, logic [3:0] b);
    bit f, c, a;
    int dg;
    @(negedge clk);
    reset = r; en = e; load = l; data = d; blank = b;
    #1;
    f = !r && e && (!m_run || m_pos == FR - 1);
    chk("an", 16'(an), 16'(m_an));
    chk("seg", 16'(seg), 16'(m_seg));
    chk("ready", 16'(ready), 16'(!m_pend));
    chk("frame", 16'(frame), 16'(f));
    for (int i = 0; i < 4; i++) if (!an[i] && an != 4'hF) obs[i] = seg;
    c = m_pend && (!m_run || f);
    a = l && !m_pend;
    @(posedge clk);
    if (r) begin
      m_run = 0; m_pos = 0; m_act = '0; m_sh = '0; m_pend = 0; m_an = 4'hF; m_seg = 7'h7F;
    end else begin
      dg = m_pos / P;
      if (m_run && m_pos % P < TD) begin
        m_an = ~(4'b0001 << dg);
        m_seg = b[dg] ? 7'h7F : dec[m_act[4*dg +: 4]];
      end else begin
        m_an = 4'hF;
        m_seg = 7'h7F;
      end
      if (c) begin m_act = m_sh; m_pend = 0; end
      if (a) begin m_sh = d; m_pend = 1; end
      if (!e) begin m_run = 0; m_pos = 0; end
      else if (!m_run) begin m_run = 1; m_pos = 0; end
      else m_pos = (m_pos + 1) % FR;
    end
  endtask
  initial begin
    logic [15:0] rd;
    logic [3:0] rb;
    bit ren;
    dec = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vt[0] = '{16'h0000, 1'b0, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}};
    vt[1] = '{16'hF8A1, 1'b1, 4'b0000, {7'h0E, 7'h00, 7'h08, 7'h79}};
    vt[2] = '{16'h1234, 1'b1, 4'b0100, {7'h79, 7'h7F, 7'h30, 7'h19}};
    vt[3] = '{16'h9C5E, 1'b1, 4'b0000, {7'h10, 7'h46, 7'h12, 7'h06}};
    vt[4] = '{16'h7B6D, 1'b1, 4'b0000, {7'h78, 7'h03, 7'h02, 7'h21}};
    vt[5] = '{16'hF8A1, 1'b1, 4'b1001, {7'h7F, 7'h00, 7'h08, 7'h7F}};
    m_run = 0; m_pos = 0; m_act = '0; m_sh = '0; m_pend = 0; m_an = 4'hF; m_seg = 7'h7F;
    repeat (2) @(posedge clk);
    step(1, 1, 1, 16'hFFFF, 4'h0);
    chk("reset_an", 16'(an), 16'h000F);
    chk("reset_ready", 16'(ready), 16'h0001);
    for (int v = 0; v < 6; v++) begin
      step(1, 0, 0, 16'h0, 4'h0);
      if (vt[v].ld) step(0, 0, 1, vt[v].d, vt[v].b);
      repeat (2) step(0, 0, 0, 16'h0, vt[v].b);
      clear_obs();
      repeat (FR + 2) step(0, 1, 0, 16'h0, vt[v].b);
      for (int i = 0; i < 4; i++) chk($sformatf("vec%0d_dig%0d", v, i), 16'(obs[i]), 16'(vt[v].e[7*i +: 7]));
    end
    step(1, 0, 0, 16'h0, 4'h0);
    step(0, 0, 1, 16'hF8A1, 4'h0);
    repeat (P + 3) step(0, 1, 0, 16'h0, 4'h0);
    step(0, 1, 1, 16'h1234, 4'h0);
    #2 chk("ready_low_after_load", 16'(ready), 16'h0000);
    step(0, 1, 1, 16'h5555, 4'h0);
    repeat (FR - 1) step(0, 1, 0, 16'h0, 4'h0);
    clear_obs();
    repeat (FR) step(0, 1, 0, 16'h0, 4'h0);
    for (int i = 0; i < 4; i++) chk($sformatf("newval_dig%0d", i), 16'(obs[i]), 16'(dec[4-i]));
    for (int k = 0; k < FR && m_pos != 2 * P + 1; k++) step(0, 1, 0, 16'h0, 4'h0);
    chk("reached_dig2", 16'(m_pos), 16'(2 * P + 1));
    step(0, 0, 0, 16'h0, 4'h0);
    step(0, 0, 0, 16'h0, 4'h0);
    #2 chk("an_off_after_en_drop", 16'(an), 16'h000F);
    repeat (P + 2) step(0, 1, 0, 16'h0, 4'h0);
    step(0, 1, 1, 16'h9999, 4'h0);
    step(1, 1, 0, 16'h0, 4'h0);
    #2 chk("ready_after_reset", 16'(ready), 16'h0001);
    chk("an_after_reset", 16'(an), 16'h000F);
    clear_obs();
    repeat (FR + 2) step(0, 1, 0, 16'h0, 4'h0);
    for (int i = 0; i < 4; i++) chk($sformatf("zero_after_reset_dig%0d", i), 16'(obs[i]), 16'h0040);
    ren = 1; rb = 0;
    repeat (3000) begin
      if ($urandom_range(0, 49) == 0) ren = !ren;
      if ($urandom_range(0, 15) == 0) rb = 4'($urandom);
      rd = 16'($urandom);
      step($urandom_range(0, 199) == 0, ren, $urandom_range(0, 7) == 0, rd, rb);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
